// File: rtl/spi_reg_writer_if.sv
// Request-side bundle of spi_reg_writer: address/data handshake plus status.
// The requester uses the master modport; the SPI controller uses slave.
interface spi_reg_writer_if;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       busy;
  logic       done;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, busy, done
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, busy, done
  );
endinterface

// File: rtl/spi_reg_writer.sv
// SPI mode-0 write-only controller: sends {1'b1, addr[6:0], data[7:0]} MSB
// first, one request at a time, with lead, nCS-hold and inter-frame gap timing.
module spi_reg_writer #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_reg_writer_if.slave    req,
  output logic               sclk,
  output logic               copi,
  output logic               ncs
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = $clog2(CS_GAP + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(CS_GAP - 1);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, GAP} state_t;

  state_t        state, state_nx;
  logic [HW-1:0] half_cnt, half_cnt_nx;
  logic [4:0]    bit_cnt, bit_cnt_nx;
  logic [GW-1:0] gap_cnt, gap_cnt_nx;
  logic [15:0]   shift_reg, shift_nx;
  logic          sclk_nx, ncs_nx;
  logic          ready_r, ready_nx;
  logic          busy_r, busy_nx;
  logic          done_r, done_nx;
  logic          half_last;

  assign half_last = (half_cnt == HALF_LAST);

  // copi is the shift register MSB; clearing the register on entry to GAP
  // and in reset is what parks copi low whenever nCS is high.
  assign copi          = shift_reg[15];
  assign req.req_ready = ready_r;
  assign req.busy      = busy_r;
  assign req.done      = done_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      half_cnt  <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      shift_reg <= '0;
      sclk      <= 1'b0;
      ncs       <= 1'b1;
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state     <= state_nx;
      half_cnt  <= half_cnt_nx;
      bit_cnt   <= bit_cnt_nx;
      gap_cnt   <= gap_cnt_nx;
      shift_reg <= shift_nx;
      sclk      <= sclk_nx;
      ncs       <= ncs_nx;
      ready_r   <= ready_nx;
      busy_r    <= busy_nx;
      done_r    <= done_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    half_cnt_nx = half_cnt;
    bit_cnt_nx  = bit_cnt;
    gap_cnt_nx  = gap_cnt;
    shift_nx    = shift_reg;
    sclk_nx     = sclk;
    ncs_nx      = ncs;
    ready_nx    = ready_r;
    busy_nx     = busy_r;
    done_nx     = 1'b0;

    case (state)
      IDLE: begin
        if (req.req_valid) begin
          state_nx    = LEAD;
          shift_nx    = {1'b1, req.req_addr, req.req_data};
          half_cnt_nx = '0;
          bit_cnt_nx  = '0;
          ncs_nx      = 1'b0;
          ready_nx    = 1'b0;
          busy_nx     = 1'b1;
        end
      end

      LEAD: begin
        if (half_last) begin
          half_cnt_nx = '0;
          sclk_nx     = 1'b1;
          state_nx    = SHIFT;
        end else begin
          half_cnt_nx = half_cnt + 1'b1;
        end
      end

      // bit_cnt counts completed high phases; the low phase after the 16th
      // keeps bit 0 on copi and acts as the nCS hold time.
      SHIFT: begin
        if (!half_last) begin
          half_cnt_nx = half_cnt + 1'b1;
        end else begin
          half_cnt_nx = '0;
          if (sclk) begin
            sclk_nx    = 1'b0;
            bit_cnt_nx = bit_cnt + 1'b1;
            if (bit_cnt != 5'd15) begin
              shift_nx = {shift_reg[14:0], 1'b0};
            end
          end else if (bit_cnt == 5'd16) begin
            state_nx   = GAP;
            ncs_nx     = 1'b1;
            shift_nx   = '0;
            gap_cnt_nx = '0;
            done_nx    = 1'b1;
          end else begin
            sclk_nx = 1'b1;
          end
        end
      end

      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nx = IDLE;
          ready_nx = 1'b1;
          busy_nx  = 1'b0;
        end else begin
          gap_cnt_nx = gap_cnt + 1'b1;
        end
      end

      default: begin
        state_nx = IDLE;
        ncs_nx   = 1'b1;
        sclk_nx  = 1'b0;
        shift_nx = '0;
        ready_nx = 1'b1;
        busy_nx  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_reg_writer.sv
// Directed bench for spi_reg_writer: default instance (CLK_DIV=4, CS_GAP=2)
// and a fast instance (CLK_DIV=2, CS_GAP=1), watched by a negedge SPI monitor.
module tb_spi_reg_writer;

  logic clk;
  logic rst_n_a, rst_n_b;
  logic sclk_a, copi_a, ncs_a;
  logic sclk_b, copi_b, ncs_b;
  int   checks;
  int   errors;

  spi_reg_writer_if bus_a ();
  spi_reg_writer_if bus_b ();

  spi_reg_writer #(.CLK_DIV(4), .CS_GAP(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .req   (bus_a),
    .sclk  (sclk_a),
    .copi  (copi_a),
    .ncs   (ncs_a)
  );

  spi_reg_writer #(.CLK_DIV(2), .CS_GAP(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .req   (bus_b),
    .sclk  (sclk_b),
    .copi  (copi_b),
    .ncs   (ncs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic sample_pins(input bit sel, output logic n, output logic s, output logic c,
                             output logic r, output logic b, output logic d);
    if (sel) begin
      n = ncs_b; s = sclk_b; c = copi_b; r = bus_b.req_ready; b = bus_b.busy; d = bus_b.done;
    end else begin
      n = ncs_a; s = sclk_a; c = copi_a; r = bus_a.req_ready; b = bus_a.busy; d = bus_a.done;
    end
  endtask

  task automatic drive_req(input bit sel, input logic v, input logic [6:0] a, input logic [7:0] d);
    if (sel) begin
      bus_b.req_valid = v; bus_b.req_addr = a; bus_b.req_data = d;
    end else begin
      bus_a.req_valid = v; bus_a.req_addr = a; bus_a.req_data = d;
    end
  endtask

  // Monitor one frame: waits for nCS low, shifts copi on each sclk rise and
  // tallies timing, handshake and done-pulse anomalies until nCS rises.
  task automatic capture(input bit sel, input int div, output logic [15:0] word,
                         output int low_cycles, output int pre_high, output int rises,
                         output int done_cnt, output int done_ok, output int timing_err,
                         output int ready_err, output bit timeout);
    logic n, s, c, r, b, d, ps, pc;
    int   cyc, last_change, last_rise;
    bit   ended;
    word = '0; low_cycles = 0; pre_high = 0; rises = 0; done_cnt = 0; done_ok = 0;
    timing_err = 0; ready_err = 0; timeout = 1'b1; ended = 1'b0;
    n = 1'b1; s = 1'b0; c = 1'b0; r = 1'b0; b = 1'b0; d = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      sample_pins(sel, n, s, c, r, b, d);
      if (n === 1'b0) break;
      pre_high++;
    end
    if (n !== 1'b0) return;
    low_cycles = 1; cyc = 0; last_change = 0; last_rise = -1000; ps = s; pc = c;
    if (r !== 1'b0) ready_err++;
    if (b !== 1'b1) ready_err++;
    if (d !== 1'b0) done_cnt++;
    if (s !== 1'b0) timing_err++;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      sample_pins(sel, n, s, c, r, b, d);
      cyc++;
      if (n === 1'b1) begin
        ended = 1'b1;
        if (d === 1'b1) begin done_cnt++; done_ok = 1; end
        if (s !== 1'b0 || ps !== 1'b0) timing_err++;
        if (c !== 1'b0) timing_err++;
        break;
      end
      low_cycles++;
      if (r !== 1'b0) ready_err++;
      if (b !== 1'b1) ready_err++;
      if (d !== 1'b0) done_cnt++;
      if (c !== pc) begin
        if (cyc - last_rise < div) timing_err++;
        last_change = cyc;
      end
      if (s === 1'b1 && ps === 1'b0) begin
        rises++;
        word = {word[14:0], c};
        if (cyc - last_change < div) timing_err++;
        last_rise = cyc;
      end
      ps = s; pc = c;
    end
    timeout = !ended;
  endtask

  task automatic test_reset();
    logic n, s, c, r, b, d;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    drive_req(0, 1'b0, 7'h00, 8'h00);
    drive_req(1, 1'b0, 7'h00, 8'h00);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      sample_pins(k[0], n, s, c, r, b, d);
      checks++;
      if ({n, s, c, r, b, d} !== 6'b100100) begin
        errors++;
        $display("[TB] FAIL reset_state dut%0d got ncs,sclk,copi,ready,busy,done=%b want 100100",
                 k, {n, s, c, r, b, d});
      end
    end
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      sample_pins(k[0], n, s, c, r, b, d);
      checks++;
      if ({n, s, c, r, b, d} !== 6'b100100) begin
        errors++;
        $display("[TB] FAIL idle_after_reset dut%0d got %b want 100100", k, {n, s, c, r, b, d});
      end
    end
  endtask

  task automatic test_single_write(input bit sel, input int div, input int gap,
                                   input logic [6:0] addr, input logic [7:0] data,
                                   input logic [15:0] exp_word, input int exp_low,
                                   input string tag);
    logic [15:0] word;
    int low, pre, rises, dcnt, dok, terr, rerr, k;
    bit tmo;
    logic n, s, c, r, b, d;
    @(negedge clk);
    drive_req(sel, 1'b1, addr, data);
    fork
      capture(sel, div, word, low, pre, rises, dcnt, dok, terr, rerr, tmo);
      begin
        @(posedge clk);
        #1;
        drive_req(sel, 1'b0, 7'h7F, 8'hFF);
      end
    join
    checks++;
    if (tmo) begin errors++; $display("[TB] FAIL %s_timeout frame never completed", tag); end
    checks++;
    if (word !== exp_word) begin errors++; $display("[TB] FAIL %s_frame got %h want %h", tag, word, exp_word); end
    checks++;
    if (rises != 16) begin errors++; $display("[TB] FAIL %s_rises got %0d want 16", tag, rises); end
    checks++;
    if (low != exp_low) begin errors++; $display("[TB] FAIL %s_ncs_low got %0d want %0d", tag, low, exp_low); end
    checks++;
    if (dcnt != 1 || dok != 1) begin
      errors++; $display("[TB] FAIL %s_done got count %0d at_rise %0d want 1 1", tag, dcnt, dok);
    end
    checks++;
    if (terr != 0) begin errors++; $display("[TB] FAIL %s_timing got %0d violations want 0", tag, terr); end
    checks++;
    if (rerr != 0) begin errors++; $display("[TB] FAIL %s_ready_busy got %0d violations want 0", tag, rerr); end
    k = 0;
    r = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      sample_pins(sel, n, s, c, r, b, d);
      if (i == 1) begin
        checks++;
        if (d !== 1'b0) begin errors++; $display("[TB] FAIL %s_done_width got %b want 0", tag, d); end
      end
      k = i;
      if (r === 1'b1) break;
    end
    checks++;
    if (k != gap || b !== 1'b0 || n !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_ready_return got %0d cycles busy %b want %0d cycles busy 0", tag, k, b, gap);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w1, w2;
    int low1, pre1, ri1, dc1, do1, te1, re1;
    int low2, pre2, ri2, dc2, do2, te2, re2;
    bit to1, to2, seen_high;
    @(negedge clk);
    drive_req(0, 1'b1, 7'h01, 8'h0F);
    fork
      begin
        capture(0, 4, w1, low1, pre1, ri1, dc1, do1, te1, re1, to1);
        capture(0, 4, w2, low2, pre2, ri2, dc2, do2, te2, re2, to2);
      end
      begin
        @(posedge clk);
        #1;
        drive_req(0, 1'b1, 7'h03, 8'hF0);
        seen_high = 1'b0;
        for (int i = 0; i < 400; i++) begin
          @(posedge clk);
          #1;
          if (ncs_a === 1'b1) seen_high = 1'b1;
          if (seen_high && ncs_a === 1'b0) break;
        end
        drive_req(0, 1'b0, 7'h00, 8'h00);
      end
    join
    checks++;
    if (to1 || to2) begin errors++; $display("[TB] FAIL b2b_timeout got %b%b want 00", to1, to2); end
    checks++;
    if (w1 !== 16'h810F) begin errors++; $display("[TB] FAIL b2b_frame1 got %h want 810f", w1); end
    checks++;
    if (w2 !== 16'h83F0) begin errors++; $display("[TB] FAIL b2b_frame2 got %h want 83f0", w2); end
    checks++;
    if (pre2 + 1 != 3) begin errors++; $display("[TB] FAIL b2b_gap got %0d high cycles want 3", pre2 + 1); end
    checks++;
    if (re1 != 0 || re2 != 0) begin
      errors++; $display("[TB] FAIL b2b_ready_low got %0d/%0d violations want 0/0", re1, re2);
    end
    checks++;
    if (low1 != 132 || low2 != 132 || dc1 != 1 || dc2 != 1) begin
      errors++;
      $display("[TB] FAIL b2b_frames got low %0d/%0d done %0d/%0d want 132/132 1/1", low1, low2, dc1, dc2);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_input_stability();
    logic [15:0] word;
    int low, pre, rises, dcnt, dok, terr, rerr;
    bit tmo;
    @(negedge clk);
    drive_req(0, 1'b1, 7'h02, 8'h55);
    fork
      capture(0, 4, word, low, pre, rises, dcnt, dok, terr, rerr, tmo);
      begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 600; i++) begin
          drive_req(0, 1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom));
          @(posedge clk);
          #1;
          if (ncs_a === 1'b1) break;
        end
        drive_req(0, 1'b0, 7'h00, 8'h00);
      end
    join
    checks++;
    if (tmo || word !== 16'h8255) begin
      errors++; $display("[TB] FAIL stability_frame got %h timeout %b want 8255", word, tmo);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (ncs_a !== 1'b1 || bus_a.req_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL stability_idle got ncs %b ready %b want 1 1", ncs_a, bus_a.req_ready);
    end
  endtask

  task automatic test_reset_mid_frame();
    int rises;
    logic ps;
    @(negedge clk);
    drive_req(0, 1'b1, 7'h04, 8'h80);
    @(posedge clk);
    #1;
    drive_req(0, 1'b0, 7'h00, 8'h00);
    rises = 0;
    ps = sclk_a;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sclk_a === 1'b1 && ps === 1'b0) rises++;
      ps = sclk_a;
      if (rises == 5) break;
    end
    checks++;
    if (rises != 5 || sclk_a !== 1'b1 || ncs_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_setup got rises %0d sclk %b ncs %b want 5 1 0", rises, sclk_a, ncs_a);
    end
    #2;
    rst_n_a = 1'b0;
    #1;
    checks++;
    if ({ncs_a, sclk_a, copi_a, bus_a.req_ready, bus_a.busy} !== 5'b10010) begin
      errors++;
      $display("[TB] FAIL midreset_async got ncs,sclk,copi,ready,busy=%b want 10010",
               {ncs_a, sclk_a, copi_a, bus_a.req_ready, bus_a.busy});
    end
    repeat (2) @(negedge clk);
    rst_n_a = 1'b1;
    @(negedge clk);
    test_single_write(0, 4, 2, 7'h01, 8'h3C, 16'h813C, 132, "after_reset");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_write(0, 4, 2, 7'h04, 8'h80, 16'h8480, 132, "single");
    test_back_to_back();
    test_input_stability();
    test_reset_mid_frame();
    test_single_write(1, 2, 1, 7'h00, 8'hAA, 16'h80AA, 66, "sweep");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_writer.md
# spi_reg_writer

SPI controller (initiator) that drives write frames into the chip's SPI register peripheral, which feeds the PWM block's enable and duty-cycle registers. It accepts one address/data request at a time over a valid/ready handshake and serialises it as a 16-bit mode-0 frame: write flag, 7-bit address, 8-bit data, MSB first. It is used as the bench-side and FPGA-side stimulus master for the register map, and as the on-chip master in loopback builds.

## Interface
- CLK_DIV, default 4: clk cycles per SCLK half-period; legal range ≥2.
- CS_GAP, default 2: minimum clk cycles nCS stays high between frames; legal range ≥1.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request (high only in IDLE).
- req_addr  input  7  target register address.
- req_data  input  8  register write data.
- busy  output  1  high from acceptance until return to IDLE.
- done  output  1  one-cycle pulse when a frame completes.
- sclk  output  1  SPI clock, idle low (mode 0).
- copi  output  1  controller-out/peripheral-in data.
- ncs  output  1  chip select, active low.

## Operation
- Register map targeted: 0x00 en_reg_out_7_0, 0x01 en_reg_out_15_8, 0x02 en_reg_pwm_7_0, 0x03 en_reg_pwm_15_8, 0x04 pwm_duty_cycle. The block does not range-check addresses; it sends any 7-bit value.
- Frame word = {1'b1, req_addr, req_data}, latched into a 16-bit shift register on the accept edge (req_valid & req_ready). Inputs are ignored at all other times.
- The block only writes. Bit 15 is always 1.
- States:
  - IDLE: req_ready=1, ncs=1, sclk=0. Moves to LEAD on accept.
  - LEAD: ncs=0, copi=frame[15], sclk=0 for CLK_DIV cycles.
  - SHIFT: alternates a high phase (sclk=1, CLK_DIV cycles) and a low phase (sclk=0, CLK_DIV cycles), 16 times. copi advances to the next bit at the start of each low phase except the 16th.
  - GAP: ncs=1 for CS_GAP cycles, then IDLE.
- The 16th low phase serves as the nCS hold time. copi holds bit 0 through that phase and drives 0 once ncs is high.
- A 5-bit bit counter and a half-period counter of width clog2(CLK_DIV) are used. No wrap beyond 16 bits.
- req_valid held high continuously produces back-to-back frames separated by exactly CS_GAP high cycles plus the IDLE accept cycle.
- All outputs are registered. No combinational path from inputs to outputs.

## Timing
- Reset values: req_ready=1, busy=0, done=0, sclk=0, copi=0, ncs=1. Counters and shift register are cleared.
- Reset asserted mid-frame: ncs=1, sclk=0 and copi=0 take effect asynchronously. The partial frame is abandoned and not retried. After rst_n deasserts, the block is in IDLE on the first clk edge.
- Accept at edge T:
  - ncs falls and copi=frame[15] at T+1.
  - First sclk rise at T+1+CLK_DIV.
  - Rising edges at T+1+CLK_DIV·(1+2k), k=0..15.
  - ncs rises at T+1+33·CLK_DIV. done=1 for that single cycle.
  - req_ready returns at T+1+33·CLK_DIV+CS_GAP.
- With defaults, ncs is low for 132 cycles.
- copi is stable for CLK_DIV cycles before and after every sclk rising edge. ncs never changes while sclk=1.
- busy is high from T+1 through the last GAP cycle.

## Test plan
- Single write, addr 0x04, data 0x80, defaults:
  - Bench SPI monitor captures 0x8480 on 16 sclk rising edges.
  - ncs low for 132 cycles; done pulses once, on the ncs rise cycle.
- Loopback into the SPI register peripheral plus PWM block, writing 0x00=0xFF, 0x02=0xFF, 0x04=0x40:
  - en_reg_out_7_0=0xFF, en_reg_pwm_7_0=0xFF, pwm_duty_cycle=0x40.
  - uo_out toggles at 25% duty.
- Back-to-back: req_valid held high, requests (0x01,0x0F) then (0x03,0xF0):
  - Frames 0x810F then 0x83F0.
  - ncs high for exactly CS_GAP+1 cycles between them; req_ready low throughout each frame.
- Input stability: change req_addr/req_data every cycle while busy.
  - Captured frame equals the values present on the accept edge.
- Reset mid-frame: assert rst_n low after the 5th sclk rise.
  - ncs=1, sclk=0, copi=0 within the same cycle, with no clk edge needed.
  - The peripheral's registers are unchanged.
  - The next request after reset produces a clean full frame.
- Parameter sweep CLK_DIV=2 and CS_GAP=1:
  - ncs low for 66 cycles.
  - copi stable ≥2 cycles around each rising edge.
  - Frame 0x80AA is captured correctly for addr 0x00, data 0xAA.
